// File: rtl/host_switch_if.sv
// Signal bundle between the host-switch controller and the board/command side.
interface host_switch_if;
  logic hb_a, hb_b;
  logic power_on_A, power_on_B;
  logic reset_A, reset_B;
  logic force_swi, com_swi;
  logic switch, swi_pulse;
  logic a_alive, b_alive, no_host;

  modport master (
    output hb_a, hb_b, power_on_A, power_on_B, reset_A, reset_B, force_swi, com_swi,
    input  switch, swi_pulse, a_alive, b_alive, no_host
  );
  modport slave (
    input  hb_a, hb_b, power_on_A, power_on_B, reset_A, reset_B, force_swi, com_swi,
    output switch, swi_pulse, a_alive, b_alive, no_host
  );
endinterface

// File: rtl/host_switch_ctrl.sv
// Dual-CPU host selection: per-CPU heartbeat monitors, forced switching,
// heartbeat-loss failover and a hold-off window between host changes.
module hb_mon #(
  parameter int HB_TIMEOUT = 1000,
  parameter int CNT_W      = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic hb,
  input  logic pwr,
  input  logic cpu_rst,
  output logic alive,
  output logic alive_nxt
);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(HB_TIMEOUT);

  logic             hb_prev;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (hb != hb_prev)  cnt_nxt = '0;
    else if (cnt < TMO) cnt_nxt = cnt + CNT_W'(1);
    alive_nxt = pwr & ~cpu_rst & (cnt_nxt < TMO);
  end

  // hb_prev follows hb even in reset so leaving reset never looks like an edge
  always_ff @(posedge clk) begin
    hb_prev <= hb;
    if (rst) begin
      cnt   <= TMO;
      alive <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      alive <= alive_nxt;
    end
  end
endmodule

module host_switch_ctrl #(
  parameter int HB_TIMEOUT = 1000,
  parameter int HOLDOFF    = 64,
  parameter int CNT_W      = 32
) (
  input  logic         clk,
  input  logic         rst,
  host_switch_if.slave bus
);
  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLDOFF - 1);

  typedef enum logic [1:0] {ST_A, ST_B, ST_HOLD} state_t;

  logic [1:0] hb, pwr, crst, alive, alive_nxt;
  assign hb   = {bus.hb_b, bus.hb_a};
  assign pwr  = {bus.power_on_B, bus.power_on_A};
  assign crst = {bus.reset_B, bus.reset_A};

  for (genvar i = 0; i < 2; i++) begin : g_mon
    hb_mon #(.HB_TIMEOUT(HB_TIMEOUT), .CNT_W(CNT_W)) u_mon (
      .clk(clk), .rst(rst), .hb(hb[i]), .pwr(pwr[i]), .cpu_rst(crst[i]),
      .alive(alive[i]), .alive_nxt(alive_nxt[i])
    );
  end

  state_t           state, state_nxt;
  logic             sw, sw_nxt, pulse, pulse_nxt;
  logic             pend, pend_nxt, psel, psel_nxt;
  logic             eff_pend, eff_sel, do_sw, nh;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;

  always_comb begin
    state_nxt = state;
    sw_nxt    = sw;
    pulse_nxt = 1'b0;
    pend_nxt  = pend;
    psel_nxt  = psel;
    hold_nxt  = hold_cnt;
    do_sw     = 1'b0;
    // a force arriving this cycle overrides any stored one
    eff_pend  = pend | bus.force_swi;
    eff_sel   = bus.force_swi ? bus.com_swi : psel;
    case (state)
      ST_A: begin
        if (bus.force_swi) do_sw = bus.com_swi;
        else               do_sw = ~alive[0] & alive[1];
      end
      ST_B: begin
        if (bus.force_swi) do_sw = ~bus.com_swi;
        else               do_sw = ~alive[1] & alive[0];
      end
      ST_HOLD: begin
        if (hold_cnt == '0) begin
          if (eff_pend && (eff_sel != sw)) do_sw = 1'b1;
          else begin
            pend_nxt  = 1'b0;
            state_nxt = sw ? ST_B : ST_A;
          end
        end else begin
          hold_nxt = hold_cnt - CNT_W'(1);
          pend_nxt = eff_pend;
          psel_nxt = eff_sel;
        end
      end
      default: state_nxt = ST_A;
    endcase
    // only two hosts, so every change is a toggle
    if (do_sw) begin
      sw_nxt    = ~sw;
      pulse_nxt = 1'b1;
      hold_nxt  = HOLD_INIT;
      pend_nxt  = 1'b0;
      state_nxt = ST_HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_A;
      sw       <= 1'b0;
      pulse    <= 1'b0;
      pend     <= 1'b0;
      psel     <= 1'b0;
      hold_cnt <= '0;
      nh       <= 1'b1;
    end else begin
      state    <= state_nxt;
      sw       <= sw_nxt;
      pulse    <= pulse_nxt;
      pend     <= pend_nxt;
      psel     <= psel_nxt;
      hold_cnt <= hold_nxt;
      nh       <= ~alive_nxt[0] & ~alive_nxt[1];
    end
  end

  assign bus.switch    = sw;
  assign bus.swi_pulse = pulse;
  assign bus.a_alive   = alive[0];
  assign bus.b_alive   = alive[1];
  assign bus.no_host   = nh;
endmodule

// File: tb/tb_host_switch_ctrl.sv
// Self-checking bench for host_switch_ctrl: vector table, directed corner
// sequences and randomized traffic against a timestamp-based reference model.
module tb_host_switch_ctrl;
  localparam int HB_TIMEOUT = 1000;
  localparam int HOLDOFF    = 64;
  localparam int HB_PER     = 100;
  localparam longint NEVER  = -1000000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  host_switch_if bus ();

  host_switch_ctrl #(.HB_TIMEOUT(HB_TIMEOUT), .HOLDOFF(HOLDOFF), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  longint cyc = 0;
  bit     run_a = 0, run_b = 0;
  longint last_a = 0;

  // reference model: host, time of last change, last heartbeat edge times
  longint m_last [2];
  logic   m_prev [2];
  logic   m_al   [2];
  logic   m_host, m_pulse, m_nh, m_inhold, m_pend, m_sel;
  longint m_chg;

  typedef struct {
    logic rst, hb_a, hb_b, pa, pb, ra, rb, frc, com;
    logic [4:0] exp;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, want);
    end
  endtask

  task automatic model();
    logic hbv [2], pw [2], cr [2];
    logic chg;
    hbv = '{bus.hb_a, bus.hb_b};
    pw  = '{bus.power_on_A, bus.power_on_B};
    cr  = '{bus.reset_A, bus.reset_B};
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_prev[i] = hbv[i]; m_last[i] = NEVER; m_al[i] = 1'b0;
      end
      m_host = 0; m_pulse = 0; m_nh = 1; m_inhold = 0; m_pend = 0; m_sel = 0;
    end else begin
      chg = 1'b0;
      m_pulse = 1'b0;
      if (m_inhold) begin
        if (bus.force_swi) begin m_pend = 1; m_sel = bus.com_swi; end
        if (cyc - m_chg >= HOLDOFF) begin
          if (m_pend && m_sel != m_host) chg = 1'b1;
          else begin m_inhold = 0; m_pend = 0; end
        end
      end else if (bus.force_swi) chg = (bus.com_swi != m_host);
      else chg = m_host ? (!m_al[1] && m_al[0]) : (!m_al[0] && m_al[1]);
      if (chg) begin
        m_host = ~m_host; m_pulse = 1; m_inhold = 1; m_chg = cyc; m_pend = 0;
      end
      for (int i = 0; i < 2; i++) begin
        if (hbv[i] != m_prev[i]) m_last[i] = cyc;
        m_prev[i] = hbv[i];
        m_al[i] = pw[i] && !cr[i] && (cyc - m_last[i] < HB_TIMEOUT);
      end
      m_nh = !m_al[0] && !m_al[1];
    end
  endtask

  function automatic logic [4:0] dut_vec();
    return {bus.switch, bus.swi_pulse, bus.a_alive, bus.b_alive, bus.no_host};
  endfunction

  task automatic step();
    cyc++;
    if (run_a && cyc % HB_PER == 0) begin bus.hb_a = ~bus.hb_a; last_a = cyc; end
    if (run_b && cyc % HB_PER == 0) bus.hb_b = ~bus.hb_b;
    @(posedge clk);
    model();
    #1;
    chk("model", 32'(dut_vec()), 32'({m_host, m_pulse, m_al[0], m_al[1], m_nh}));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1; step(); rst = 0;
  endtask

  task automatic idle_inputs();
    bus.power_on_A = 1; bus.power_on_B = 1;
    bus.reset_A = 0; bus.reset_B = 0;
    bus.force_swi = 0; bus.com_swi = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    longint c, fall;
    int pulses;
    bus.hb_a = 0; bus.hb_b = 0;
    idle_inputs();

    // per-cycle vectors, expected = {switch, swi_pulse, a_alive, b_alive, no_host}
    tbl[0]  = '{1,0,0,1,1,0,0,0,0,5'b00001};
    tbl[1]  = '{0,0,0,1,1,0,0,0,0,5'b00001};
    tbl[2]  = '{0,1,0,1,1,0,0,0,0,5'b00100};
    tbl[3]  = '{0,1,1,1,1,0,0,0,0,5'b00110};
    tbl[4]  = '{0,1,1,1,1,0,0,1,1,5'b11110};
    tbl[5]  = '{0,1,1,1,1,0,0,0,0,5'b10110};
    tbl[6]  = '{0,1,1,1,1,0,0,1,0,5'b10110};
    tbl[7]  = '{0,1,1,1,1,1,0,0,0,5'b10010};
    tbl[8]  = '{0,1,1,1,1,0,0,0,0,5'b10110};
    tbl[9]  = '{0,1,1,1,0,0,0,0,0,5'b10100};
    tbl[10] = '{0,1,1,0,0,0,0,0,0,5'b10001};
    tbl[11] = '{1,1,1,1,1,0,0,0,0,5'b00001};
    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst; bus.hb_a = tbl[i].hb_a; bus.hb_b = tbl[i].hb_b;
      bus.power_on_A = tbl[i].pa; bus.power_on_B = tbl[i].pb;
      bus.reset_A = tbl[i].ra; bus.reset_B = tbl[i].rb;
      bus.force_swi = tbl[i].frc; bus.com_swi = tbl[i].com;
      step();
      chk($sformatf("vec%0d", i), 32'(dut_vec()), 32'(tbl[i].exp));
    end
    rst = 0; idle_inputs();

    // T1: both heartbeats running
    do_reset();
    run_a = 1; run_b = 1;
    steps(500);
    chk("T1 alive", 32'({bus.switch, bus.a_alive, bus.b_alive, bus.no_host}), 32'b0110);

    // T2: hb_a stops, failover after exactly HB_TIMEOUT cycles
    run_a = 0;
    fall = -1;
    for (int i = 0; i < 1200 && fall < 0; i++) begin
      step();
      if (!bus.a_alive) fall = cyc;
    end
    chk("T2 fall delay", 32'(fall - last_a), HB_TIMEOUT);
    chk("T2 switch before", 32'(bus.switch), 0);
    step();
    chk("T2 failover", 32'({bus.switch, bus.swi_pulse}), 32'b11);

    // T3: forced change, then forced return queued during hold-off
    do_reset();
    run_a = 1; run_b = 1;
    steps(150);
    bus.force_swi = 1; bus.com_swi = 1;
    step();
    c = cyc;
    bus.force_swi = 0;
    chk("T3 forced", 32'({bus.switch, bus.swi_pulse}), 32'b11);
    step();
    chk("T3 single pulse", 32'(bus.swi_pulse), 0);
    while (cyc < c + 9) step();
    bus.force_swi = 1; bus.com_swi = 0;
    step();
    bus.force_swi = 0;
    for (int i = 0; i < 200 && bus.switch; i++) step();
    chk("T3 return delay", 32'(cyc - c), HOLDOFF);
    chk("T3 return pulse", 32'(bus.swi_pulse), 1);

    // T4: force to current host beats failover in the same cycle
    do_reset();
    steps(150);
    bus.reset_A = 1;
    step();
    bus.force_swi = 1; bus.com_swi = 0;
    step();
    bus.force_swi = 0;
    chk("T4 no change", 32'({bus.switch, bus.swi_pulse}), 32'b00);
    step();
    chk("T4 failover", 32'({bus.switch, bus.swi_pulse}), 32'b11);
    bus.reset_A = 0;

    // T5: both dead, then B recovers
    do_reset();
    steps(150);
    run_a = 0; run_b = 0;
    pulses = 0;
    for (int i = 0; i < 1100; i++) begin step(); pulses += int'(bus.swi_pulse); end
    chk("T5 no_host", 32'({bus.no_host, bus.switch}), 32'b10);
    chk("T5 no pulse", 32'(pulses), 0);
    bus.hb_b = ~bus.hb_b;
    step();
    chk("T5 b back", 32'({bus.b_alive, bus.switch}), 32'b10);
    step();
    chk("T5 failover", 32'({bus.switch, bus.swi_pulse}), 32'b11);

    // T6: reset during hold-off drops the pending force
    run_a = 1; run_b = 1;
    do_reset();
    steps(150);
    bus.force_swi = 1; bus.com_swi = 1;
    step();
    c = cyc;
    bus.force_swi = 0;
    while (cyc < c + 4) step();
    bus.force_swi = 1; bus.com_swi = 0;
    step();
    bus.force_swi = 0;
    while (cyc < c + 9) step();
    rst = 1;
    step();
    rst = 0;
    chk("T6 reset", 32'(dut_vec()), 32'b00001);
    steps(150);
    chk("T6 pending lost", 32'({bus.switch, bus.a_alive, bus.b_alive}), 32'b011);
    bus.power_on_B = 0;
    step();
    chk("T6 b off", 32'(bus.b_alive), 0);
    bus.power_on_B = 1;

    // randomized traffic with long heartbeat-live/dead segments
    run_a = 0; run_b = 0;
    do_reset();
    for (int s = 0; s < 6; s++) begin
      bit la, lb;
      la = ($urandom_range(0, 2) != 0);
      lb = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < 1500; i++) begin
        if (la && $urandom_range(0, 39) == 0) bus.hb_a = ~bus.hb_a;
        if (lb && $urandom_range(0, 39) == 0) bus.hb_b = ~bus.hb_b;
        bus.force_swi = ($urandom_range(0, 24) == 0);
        bus.com_swi   = 1'($urandom);
        if ($urandom_range(0, 299) == 0) bus.power_on_A = ~bus.power_on_A;
        if ($urandom_range(0, 299) == 0) bus.power_on_B = ~bus.power_on_B;
        if ($urandom_range(0, 199) == 0) bus.reset_A = ~bus.reset_A;
        if ($urandom_range(0, 199) == 0) bus.reset_B = ~bus.reset_B;
        rst = ($urandom_range(0, 1999) == 0);
        step();
      end
    end
    rst = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
